// File: rtl/instr_align_buf_if.sv
// Line-side and decode-side signal bundle of the instruction aligner.
// The aligner uses the slave modport; its environment uses master.
interface instr_align_buf_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BUS_HW    = 4,
    parameter int unsigned FETCH_LEN = 2,
    parameter int unsigned EPOCH_W   = 2
);
    localparam int unsigned CNT_W = $clog2(FETCH_LEN + 1);

    logic                      jump_vld;
    logic [XLEN-1:0]           jump_pc;
    logic [EPOCH_W-1:0]        epoch;
    logic                      line_vld;
    logic                      line_rdy;
    logic [16*BUS_HW-1:0]      line_data;
    logic                      line_err;
    logic [EPOCH_W-1:0]        line_epoch;
    logic [FETCH_LEN-1:0]      fetch_vld;
    logic [FETCH_LEN*XLEN-1:0] fetch_instr;
    logic [FETCH_LEN*XLEN-1:0] fetch_pc;
    logic [FETCH_LEN-1:0]      fetch_rvc;
    logic [FETCH_LEN-1:0]      fetch_err;
    logic [CNT_W-1:0]          fetch_cnt;

    modport master (
        output jump_vld, jump_pc, line_vld, line_data, line_err, line_epoch, fetch_cnt,
        input  epoch, line_rdy, fetch_vld, fetch_instr, fetch_pc, fetch_rvc, fetch_err
    );

    modport slave (
        input  jump_vld, jump_pc, line_vld, line_data, line_err, line_epoch, fetch_cnt,
        output epoch, line_rdy, fetch_vld, fetch_instr, fetch_pc, fetch_rvc, fetch_err
    );
endinterface

// File: rtl/instr_align_buf.sv
// Fetch-side RV32IC aligner: queues line halfwords in a shift buffer and presents
// up to FETCH_LEN decoded 16/32-bit instructions per cycle, with same-cycle line bypass.
module instr_align_buf #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BUS_HW    = 4,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned FETCH_LEN = 2,
    parameter int unsigned EPOCH_W   = 2
) (
    input logic              clk,
    input logic              rst,
    instr_align_buf_if.slave bus
);
    localparam int unsigned CAP   = DEPTH * BUS_HW;
    localparam int unsigned LW    = $clog2(CAP + 1) + 1;
    localparam int unsigned MW    = 2 ** LW;
    localparam int unsigned OFFW  = $clog2(BUS_HW);
    localparam int unsigned CNT_W = $clog2(FETCH_LEN + 1);

    logic [15:0]        buf_data_q [CAP];
    logic [15:0]        buf_data_d [CAP];
    logic [CAP-1:0]     buf_err_q, buf_err_d;
    logic [LW-1:0]      len_q, len_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [OFFW-1:0]    off_q, off_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;

    logic          line_rdy;
    logic          accept;
    logic [LW-1:0] imem_len;
    logic [LW-1:0] merged_len;
    logic [LW-1:0] cons;
    logic [CNT_W-1:0] vld_cnt;

    // Merged view is padded to a power of two so slot lookahead never leaves the array.
    logic [15:0]   m_data [MW];
    logic [MW-1:0] m_err;
    logic [LW-1:0] starts [FETCH_LEN+1];

    logic [FETCH_LEN-1:0]      slot_vld, slot_rvc, slot_err;
    logic [FETCH_LEN*XLEN-1:0] slot_instr, slot_pc;

    logic unused_jpc;
    assign unused_jpc = bus.jump_pc[0];

    assign line_rdy   = (len_q <= LW'(CAP - BUS_HW));
    assign accept     = bus.line_vld & line_rdy & (bus.line_epoch == epoch_q);
    assign imem_len   = accept ? (LW'(BUS_HW) - LW'(off_q)) : '0;
    assign merged_len = len_q + imem_len;

    always_comb begin
        logic [LW-1:0] pos;
        pos = '0;
        for (int j = 0; j < MW; j++) begin
            m_data[j] = '0;
        end
        m_err = '0;
        for (int j = 0; j < CAP; j++) begin
            if (LW'(j) < len_q) begin
                m_data[j] = buf_data_q[j];
                m_err[j]  = buf_err_q[j];
            end
        end
        for (int k = 0; k < BUS_HW; k++) begin
            if (accept && (OFFW'(k) >= off_q)) begin
                pos         = len_q + LW'(k) - LW'(off_q);
                m_data[pos] = bus.line_data[16*k +: 16];
                m_err[pos]  = bus.line_err;
            end
        end
    end

    always_comb begin
        logic [LW-1:0] s;
        logic [15:0]   hw_lo;
        logic [15:0]   hw_hi;
        s          = '0;
        hw_lo      = '0;
        hw_hi      = '0;
        slot_vld   = '0;
        slot_rvc   = '0;
        slot_err   = '0;
        slot_instr = '0;
        slot_pc    = '0;
        vld_cnt    = '0;
        for (int i = 0; i < FETCH_LEN; i++) begin
            hw_lo       = m_data[s];
            hw_hi       = m_data[s + LW'(1)];
            starts[i]   = s;
            slot_rvc[i] = (hw_lo[1:0] != 2'b11);
            slot_err[i] = m_err[s] | (~slot_rvc[i] & m_err[s + LW'(1)]);
            slot_pc[i*XLEN +: XLEN]    = pc_q + (XLEN'(s) << 1);
            slot_instr[i*XLEN +: XLEN] = slot_rvc[i] ? XLEN'(hw_lo) : XLEN'({hw_hi, hw_lo});
            s           = s + (slot_rvc[i] ? LW'(1) : LW'(2));
            slot_vld[i] = (s <= merged_len);
            if (slot_vld[i]) begin
                vld_cnt = vld_cnt + CNT_W'(1);
            end
        end
        starts[FETCH_LEN] = s;
    end

    always_comb begin
        cons = '0;
        for (int i = 0; i < FETCH_LEN; i++) begin
            if (CNT_W'(i) < bus.fetch_cnt) begin
                cons = starts[i+1];
            end
        end
    end

    always_comb begin
        len_d     = len_q;
        pc_d      = pc_q;
        off_d     = off_q;
        epoch_d   = epoch_q;
        buf_err_d = buf_err_q;
        for (int j = 0; j < CAP; j++) begin
            buf_data_d[j] = buf_data_q[j];
        end
        if (bus.jump_vld) begin
            len_d     = '0;
            buf_err_d = '0;
            for (int j = 0; j < CAP; j++) begin
                buf_data_d[j] = '0;
            end
            pc_d    = {bus.jump_pc[XLEN-1:1], 1'b0};
            off_d   = bus.jump_pc[OFFW:1];
            epoch_d = epoch_q + EPOCH_W'(1);
        end else begin
            // Entries past the merged length read as zero, so the shift keeps the tail clean.
            len_d = merged_len - cons;
            for (int j = 0; j < CAP; j++) begin
                buf_data_d[j] = m_data[LW'(j) + cons];
                buf_err_d[j]  = m_err[LW'(j) + cons];
            end
            pc_d = pc_q + (XLEN'(cons) << 1);
            if (accept) begin
                off_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            pc_q      <= '0;
            off_q     <= '0;
            epoch_q   <= '0;
            buf_err_q <= '0;
            for (int j = 0; j < CAP; j++) begin
                buf_data_q[j] <= '0;
            end
        end else begin
            len_q     <= len_d;
            pc_q      <= pc_d;
            off_q     <= off_d;
            epoch_q   <= epoch_d;
            buf_err_q <= buf_err_d;
            for (int j = 0; j < CAP; j++) begin
                buf_data_q[j] <= buf_data_d[j];
            end
        end
    end

    assign bus.line_rdy    = line_rdy;
    assign bus.epoch       = epoch_q;
    assign bus.fetch_vld   = slot_vld;
    assign bus.fetch_instr = slot_instr;
    assign bus.fetch_pc    = slot_pc;
    assign bus.fetch_rvc   = slot_rvc;
    assign bus.fetch_err   = slot_err;

    // Decode may never take more slots than are offered.
    assert property (@(posedge clk) disable iff (rst || bus.jump_vld) bus.fetch_cnt <= vld_cnt);
endmodule

// File: tb/tb_instr_align_buf.sv
// Randomised scoreboard bench for instr_align_buf against a halfword-queue reference model.
module tb_instr_align_buf;
    localparam int XLEN      = 32;
    localparam int BUS_HW    = 4;
    localparam int DEPTH     = 3;
    localparam int FETCH_LEN = 2;
    localparam int EPOCH_W   = 2;
    localparam int CAP       = DEPTH * BUS_HW;
    localparam int CNT_W     = $clog2(FETCH_LEN + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_align_buf_if #(
        .XLEN(XLEN), .BUS_HW(BUS_HW), .FETCH_LEN(FETCH_LEN), .EPOCH_W(EPOCH_W)
    ) bus ();

    instr_align_buf #(
        .XLEN(XLEN), .BUS_HW(BUS_HW), .DEPTH(DEPTH), .FETCH_LEN(FETCH_LEN), .EPOCH_W(EPOCH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit                              jump;
        logic                            rdy;
        logic [EPOCH_W-1:0]              ep;
        logic [FETCH_LEN-1:0]            vld;
        logic [FETCH_LEN-1:0]            rvc;
        logic [FETCH_LEN-1:0]            err;
        logic [FETCH_LEN-1:0][XLEN-1:0]  instr;
        logic [FETCH_LEN-1:0][XLEN-1:0]  pc;
    } exp_t;

    exp_t expq[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending halfwords as a plain queue
    logic [15:0]        mq[$];
    logic               me[$];
    logic [XLEN-1:0]    mpc;
    int                 moff;
    logic [EPOCH_W-1:0] mep;

    function automatic void model_reset();
        mq.delete();
        me.delete();
        mpc  = '0;
        moff = 0;
        mep  = '0;
    endfunction

    function automatic logic [63:0] ln(logic [15:0] h0, logic [15:0] h1,
                                      logic [15:0] h2, logic [15:0] h3);
        return {h3, h2, h1, h0};
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("line_rdy", 64'(bus.line_rdy), 64'(e.rdy));
                check("epoch", 64'(bus.epoch), 64'(e.ep));
                if (!e.jump) begin
                    check("fetch_vld", 64'(bus.fetch_vld), 64'(e.vld));
                    for (int i = 0; i < FETCH_LEN; i++) begin
                        if (e.vld[i]) begin
                            check($sformatf("instr[%0d]", i),
                                  64'(bus.fetch_instr[i*XLEN +: XLEN]), 64'(e.instr[i]));
                            check($sformatf("pc[%0d]", i),
                                  64'(bus.fetch_pc[i*XLEN +: XLEN]), 64'(e.pc[i]));
                            check($sformatf("rvc[%0d]", i), 64'(bus.fetch_rvc[i]), 64'(e.rvc[i]));
                            check($sformatf("err[%0d]", i), 64'(bus.fetch_err[i]), 64'(e.err[i]));
                        end
                    end
                end
            end
        end
    end

    // One clock of stimulus; fc_req < 0 picks a random legal fetch_cnt.
    task automatic step(bit jv, logic [XLEN-1:0] jpc, bit lv, logic [63:0] ld, bit le,
                        logic [EPOCH_W-1:0] lep, int fc_req);
        logic [15:0] mh[$];
        logic        mhe[$];
        exp_t        e;
        int          st[FETCH_LEN+1];
        int          s, nv, fc;
        bit          acc, rdy, rvc, ok;
        logic [15:0] hw;
        rdy = (mq.size() <= CAP - BUS_HW);
        acc = lv && rdy && (lep == mep);
        mh  = mq;
        mhe = me;
        if (acc) begin
            for (int k = moff; k < BUS_HW; k++) begin
                mh.push_back(ld[16*k +: 16]);
                mhe.push_back(le);
            end
        end
        e.jump = jv;
        e.rdy  = rdy;
        e.ep   = mep;
        e.vld  = '0;
        e.rvc  = '0;
        e.err  = '0;
        e.instr = '0;
        e.pc    = '0;
        s  = 0;
        nv = 0;
        st[0] = 0;
        for (int i = 0; i < FETCH_LEN; i++) begin
            ok = 1'b0;
            if (nv == i && s < mh.size()) begin
                hw  = mh[s];
                rvc = (hw[1:0] != 2'b11);
                if (rvc) begin
                    ok = 1'b1;
                    e.instr[i] = {16'h0, hw};
                    e.err[i]   = mhe[s];
                end else if (s + 1 < mh.size()) begin
                    ok = 1'b1;
                    e.instr[i] = {mh[s+1], hw};
                    e.err[i]   = mhe[s] | mhe[s+1];
                end
                if (ok) begin
                    e.vld[i] = 1'b1;
                    e.rvc[i] = rvc;
                    e.pc[i]  = mpc + XLEN'(2 * s);
                    s  = s + (rvc ? 1 : 2);
                    nv = nv + 1;
                end
            end
            st[i+1] = s;
        end
        if (fc_req < 0) fc = int'($urandom_range(nv, 0));
        else            fc = (fc_req > nv) ? nv : fc_req;
        bus.jump_vld   = jv;
        bus.jump_pc    = jpc;
        bus.line_vld   = lv;
        bus.line_data  = ld;
        bus.line_err   = le;
        bus.line_epoch = lep;
        bus.fetch_cnt  = CNT_W'(fc);
        expq.push_back(e);
        @(posedge clk);
        if (jv) begin
            mq.delete();
            me.delete();
            mpc  = {jpc[XLEN-1:1], 1'b0};
            moff = int'(jpc[2:1]);
            mep  = mep + 1'b1;
        end else begin
            repeat (st[fc]) begin
                void'(mh.pop_front());
                void'(mhe.pop_front());
            end
            mq  = mh;
            me  = mhe;
            mpc = mpc + XLEN'(2 * st[fc]);
            if (acc) moff = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.line_vld = 1'b1;
        bus.jump_vld = 1'b0;
        bus.fetch_cnt = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(1, 0) == 0) h[1:0] = 2'($urandom_range(2, 0));
        return h;
    endfunction

    initial begin : stim
        logic [63:0] ld;
        logic [XLEN-1:0] jpc;
        bus.jump_vld   = 1'b0;
        bus.jump_pc    = '0;
        bus.line_vld   = 1'b0;
        bus.line_data  = '0;
        bus.line_err   = 1'b0;
        bus.line_epoch = '0;
        bus.fetch_cnt  = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0);

        // Two RVC then a 32-bit addi, bypassed in the arrival cycle
        step(1, 32'h100, 0, 0, 0, 0, 0);
        step(0, 0, 1, ln(16'h0001, 16'h0002, 16'h0093, 16'h0000), 0, mep, 0);
        step(0, 0, 0, 0, 0, mep, 2);
        step(0, 0, 0, 0, 0, mep, 1);

        // Jump into the last halfword of a line
        step(1, 32'h106, 0, 0, 0, mep, 0);
        step(0, 0, 1, ln(16'hffff, 16'hffff, 16'hffff, 16'h4501), 0, mep, 0);
        step(0, 0, 0, 0, 0, mep, 0);
        step(0, 0, 0, 0, 0, mep, 1);

        // 32-bit instruction split across two lines
        step(1, 32'h206, 0, 0, 0, mep, 0);
        step(0, 0, 1, ln(16'h0, 16'h0, 16'h0, 16'h0513), 0, mep, 0);
        step(0, 0, 1, ln(16'h0000, 16'h0001, 16'h0001, 16'h0001), 0, mep, 0);
        step(0, 0, 0, 0, 0, mep, 2);

        // Stale-epoch line is consumed but dropped
        step(1, 32'h300, 0, 0, 0, mep, 0);
        step(0, 0, 1, ln(16'h0001, 16'h0001, 16'h0001, 16'h0001), 0, mep - 1'b1, 0);
        step(0, 0, 0, 0, 0, mep, 0);
        step(0, 0, 1, ln(16'h0005, 16'h0009, 16'h000d, 16'h0011), 0, mep, 0);

        // Fill to capacity, hold a line until enough is consumed
        step(1, 32'h400, 0, 0, 0, mep, 0);
        repeat (3) step(0, 0, 1, ln(16'h0001, 16'h0001, 16'h0001, 16'h0001), 0, mep, 0);
        repeat (2) step(0, 0, 1, ln(16'h0021, 16'h0025, 16'h0029, 16'h002d), 0, mep, 0);
        repeat (3) step(0, 0, 1, ln(16'h0021, 16'h0025, 16'h0029, 16'h002d), 0, mep, 2);

        // Errored line completing a straddling 32-bit instruction
        step(1, 32'h500, 0, 0, 0, mep, 0);
        step(0, 0, 1, ln(16'h0001, 16'h0001, 16'h0001, 16'h0513), 0, mep, 0);
        step(0, 0, 1, ln(16'h0000, 16'h0001, 16'h0001, 16'h0001), 1, mep, 2);
        step(0, 0, 0, 0, 0, mep, 0);
        step(0, 0, 0, 0, 0, mep, 2);

        // Reset mid-stream
        do_reset();
        step(0, 0, 0, 0, 0, mep, 0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299, 0) == 0) do_reset();
            ld = ln(rand_hw(), rand_hw(), rand_hw(), rand_hw());
            jpc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)))
                                              : (32'h1000 + 32'($urandom_range(255, 0)) * 2);
            if ($urandom_range(15, 0) == 0) begin
                step(1, jpc, $urandom_range(1, 0) == 1, ld, 1'b0, mep, -1);
            end else begin
                step(0, 0, $urandom_range(4, 0) < 3, ld, $urandom_range(7, 0) == 0,
                     ($urandom_range(3, 0) == 0) ? mep - 1'b1 : mep, -1);
            end
        end

        repeat (2) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
